// File: rtl/btn_conditioner.sv
`timescale 1ns/1ps
// btn_conditioner: synchronises, debounces and edge-detects a raw pushbutton.
// A two-flop synchroniser feeds a four-state debounce FSM. A change is
// accepted only after DB_COUNT consecutive stable samples. The FSM then
// produces a registered debounced level and a one-cycle press pulse.
// Optional build macro: BTN_RELEASE_PULSE_EN. When it is defined, a
// one-cycle release pulse is generated. Otherwise btn_release is tied low.
module btn_conditioner #(
    parameter  int DB_COUNT = 1_000_000,
    localparam int CW       = $clog2(DB_COUNT)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM_H = 2'd1,
        HIGH  = 2'd2,
        ARM_L = 2'd3
    } state_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

    logic          sync1_q, sync2_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
`ifdef BTN_RELEASE_PULSE_EN
    logic          release_q, release_d;
`endif

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments. Every flop then
        // samples the values from before the edge, which keeps the
        // synchroniser a two-stage pipeline and not a single wire.
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: debounce counting and output pulse generation.
    always_comb begin
        // NOTE: every output of this block gets a default first. A path
        // that leaves a variable unassigned would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
        release_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = ARM_H;
                    cnt_d   = '0;
                end
            end
            ARM_H: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!sync2_q) begin
                    state_d = ARM_L;
                    cnt_d   = '0;
                end
            end
            ARM_L: begin
                if (sync2_q) begin
                    state_d = HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
                    release_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and registered outputs; reset wins over terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

`ifdef BTN_RELEASE_PULSE_EN
    // Release pulse flop, present only in the release-pulse build.
    always_ff @(posedge clk) begin
        if (reset) release_q <= 1'b0;
        else       release_q <= release_d;
    end
    assign btn_release = release_q;
`else
    assign btn_release = 1'b0;
`endif

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule
